// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, its program ROM and the execute stage.
// The master modport is the sequencer side; the slave modport is the ROM/execute side.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic              rom_read;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [2:0]        op_sel;
  logic [5:0]        dst;
  logic [5:0]        src;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              halted;
  logic              illegal;

  modport master (
    input  start, rom_data, instr_ready, redirect, redirect_addr,
    output rom_read, rom_addr, instr_valid, instr, op_sel, dst, src,
           instr_pc, halted, illegal
  );

  modport slave (
    output start, rom_data, instr_ready, redirect, redirect_addr,
    input  rom_read, rom_addr, instr_valid, instr, op_sel, dst, src,
           instr_pc, halted, illegal
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch/decode controller: reads a 1-cycle registered program ROM, decodes each
// word and issues it to the execute stage over a valid/ready handshake.
module fetch_sequencer #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned START_ADDR = 0
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FIELD_W = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   pc_q;
  logic [WORD_W-1:0]   instr_q;
  logic [OP_W-1:0]     op_sel_q;
  logic [ADDR_W-1:0]   instr_pc_q;
  logic                halted_q;
  logic                illegal_q;

  logic [OP_W-1:0]     dec_op_c;
  logic                dec_halt_c;
  logic                dec_illegal_c;
  logic                start_c;
  logic                redirect_c;
  logic                handshake_c;

  assign start_c     = bus.start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign redirect_c  = bus.redirect &&
                       ((state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE));
  assign handshake_c = (state_q == S_ISSUE) && bus.instr_ready;

  // Opcode decode of the word returned by the ROM
  always_comb begin
    dec_op_c      = '0;
    dec_halt_c    = 1'b0;
    dec_illegal_c = 1'b0;
    unique case (bus.rom_data[15:12])
      4'h1:    dec_op_c = 3'd1;
      4'h2:    dec_op_c = 3'd2;
      4'h3:    dec_op_c = 3'd3;
      4'h4:    dec_op_c = 3'd4;
      4'h5:    dec_op_c = 3'd5;
      4'hC:    dec_op_c = 3'd6;
      4'hD:    dec_op_c = 3'd7;
      4'h0: begin
        if (bus.rom_data == '0) dec_halt_c = 1'b1;
        else                    dec_illegal_c = 1'b1;
      end
      default: dec_illegal_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state; redirect always restarts fetch, but start in IDLE/HALT wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (start_c) state_d = S_FETCH;
      S_FETCH:        state_d = redirect_c ? S_FETCH : S_WAIT;
      S_WAIT: begin
        if (redirect_c)                      state_d = S_FETCH;
        else if (dec_halt_c || dec_illegal_c) state_d = S_HALT;
        else                                 state_d = S_ISSUE;
      end
      S_ISSUE:        if (redirect_c || handshake_c) state_d = S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Strobes decoded straight from the state register
  always_comb begin
    bus.rom_read    = 1'b0;
    bus.instr_valid = 1'b0;
    unique case (state_q)
      S_FETCH: bus.rom_read    = 1'b1;
      S_ISSUE: bus.instr_valid = 1'b1;
      default: ;
    endcase
  end

  // PC, instruction register and sticky status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= ADDR_W'(START_ADDR);
      instr_q    <= '0;
      op_sel_q   <= '0;
      instr_pc_q <= '0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (start_c) begin
      pc_q      <= ADDR_W'(START_ADDR);
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (redirect_c) begin
      pc_q <= bus.redirect_addr;
    end else if (state_q == S_WAIT) begin
      if (dec_illegal_c) begin
        halted_q   <= 1'b1;
        illegal_q  <= 1'b1;
        instr_q    <= bus.rom_data;
        op_sel_q   <= '0;
        instr_pc_q <= pc_q;
      end else if (dec_halt_c) begin
        halted_q <= 1'b1;
      end else begin
        instr_q    <= bus.rom_data;
        op_sel_q   <= dec_op_c;
        instr_pc_q <= pc_q;
        pc_q       <= pc_q + ADDR_W'(1);
      end
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.instr    = instr_q;
  assign bus.op_sel   = op_sel_q;
  assign bus.dst      = instr_q[11:6];
  assign bus.src      = instr_q[FIELD_W-1:0];
  assign bus.instr_pc = instr_pc_q;
  assign bus.halted   = halted_q;
  assign bus.illegal  = illegal_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of expected issues for the straight
// program plus hand-written stall, illegal, redirect and async-reset sequences.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(3)) bus ();

  fetch_sequencer #(.ADDR_W(3), .START_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom_mem [8];

  // 1-cycle registered program ROM
  always @(posedge clk) begin
    if (bus.rom_read) bus.rom_data <= rom_mem[bus.rom_addr];
  end

  int hs_cnt = 0;
  always @(posedge clk) begin
    if (bus.instr_valid && bus.instr_ready) hs_cnt <= hs_cnt + 1;
  end

  typedef struct packed {
    logic [15:0] word;
    logic [2:0]  op;
    logic [5:0]  dst;
    logic [5:0]  src;
    logic [2:0]  pc;
  } vec_t;

  vec_t vecs [7];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load_rom();
    rom_mem[0] = 16'h1042; rom_mem[1] = 16'h2043;
    rom_mem[2] = 16'h3044; rom_mem[3] = 16'h4045;
    rom_mem[4] = 16'h5046; rom_mem[5] = 16'hC3CA;
    rom_mem[6] = 16'hD3C1; rom_mem[7] = 16'h0000;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_addr = '0;
    bus.instr_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called one cycle after the triggering edge; n counts cycles since that edge
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.instr_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int reads;
    int base;

    vecs[0] = '{16'h1042, 3'd1, 6'd1,  6'd2,  3'd0};
    vecs[1] = '{16'h2043, 3'd2, 6'd1,  6'd3,  3'd1};
    vecs[2] = '{16'h3044, 3'd3, 6'd1,  6'd4,  3'd2};
    vecs[3] = '{16'h4045, 3'd4, 6'd1,  6'd5,  3'd3};
    vecs[4] = '{16'h5046, 3'd5, 6'd1,  6'd6,  3'd4};
    vecs[5] = '{16'hC3CA, 3'd6, 6'd15, 6'd10, 3'd5};
    vecs[6] = '{16'hD3C1, 3'd7, 6'd15, 6'd1,  3'd6};

    load_rom();
    reset_dut();
    rst = 1'b1;
    #1;
    chk("reset_rom_read", 32'(bus.rom_read), 32'd0);
    chk("reset_valid", 32'(bus.instr_valid), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_illegal", 32'(bus.illegal), 32'd0);
    chk("reset_instr", 32'(bus.instr), 32'd0);
    chk("reset_op_sel", 32'(bus.op_sel), 32'd0);
    chk("reset_instr_pc", 32'(bus.instr_pc), 32'd0);
    chk("reset_pc", 32'(bus.rom_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Straight program run
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      wait_valid(n);
      chk($sformatf("run%0d_latency", i), 32'(n), 32'd3);
      chk($sformatf("run%0d_instr", i), 32'(bus.instr), 32'(vecs[i].word));
      chk($sformatf("run%0d_op_sel", i), 32'(bus.op_sel), 32'(vecs[i].op));
      chk($sformatf("run%0d_dst", i), 32'(bus.dst), 32'(vecs[i].dst));
      chk($sformatf("run%0d_src", i), 32'(bus.src), 32'(vecs[i].src));
      chk($sformatf("run%0d_instr_pc", i), 32'(bus.instr_pc), 32'(vecs[i].pc));
      tick();
    end
    tick();
    tick();
    chk("run_halted", 32'(bus.halted), 32'd1);
    chk("run_illegal", 32'(bus.illegal), 32'd0);
    chk("run_halt_valid", 32'(bus.instr_valid), 32'd0);
    chk("run_halt_pc", 32'(bus.rom_addr), 32'd7);
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rom_read) reads++;
      tick();
    end
    chk("run_halt_reads", 32'(reads), 32'd0);

    // Execute stage stalls on the second instruction
    reset_dut();
    pulse_start();
    wait_valid(n);
    tick();
    wait_valid(n);
    chk("stall_first_pc", 32'(bus.instr_pc), 32'd1);
    bus.instr_ready = 1'b0;
    reads = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_valid", i), 32'(bus.instr_valid), 32'd1);
      chk($sformatf("stall%0d_instr", i), 32'(bus.instr), 32'h2043);
      if (bus.rom_read) reads++;
      tick();
    end
    bus.instr_ready = 1'b1;
    chk("stall_last_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_last_op_sel", 32'(bus.op_sel), 32'd2);
    chk("stall_last_pc", 32'(bus.instr_pc), 32'd1);
    chk("stall_reads", 32'(reads + 32'(bus.rom_read)), 32'd0);
    tick();
    chk("stall_next_read", 32'(bus.rom_read), 32'd1);
    chk("stall_next_addr", 32'(bus.rom_addr), 32'd2);
    wait_valid(n);
    chk("stall_next_latency", 32'(n), 32'd3);
    chk("stall_next_pc", 32'(bus.instr_pc), 32'd2);

    // Illegal opcode trap, then restart
    rom_mem[2] = 16'h7001;
    reset_dut();
    pulse_start();
    wait_valid(n);
    tick();
    wait_valid(n);
    chk("ill_prev_pc", 32'(bus.instr_pc), 32'd1);
    tick();
    tick();
    tick();
    chk("ill_halted", 32'(bus.halted), 32'd1);
    chk("ill_illegal", 32'(bus.illegal), 32'd1);
    chk("ill_instr", 32'(bus.instr), 32'h7001);
    chk("ill_instr_pc", 32'(bus.instr_pc), 32'd2);
    chk("ill_valid", 32'(bus.instr_valid), 32'd0);
    load_rom();
    pulse_start();
    chk("restart_halted", 32'(bus.halted), 32'd0);
    chk("restart_illegal", 32'(bus.illegal), 32'd0);
    wait_valid(n);
    chk("restart_latency", 32'(n), 32'd3);
    chk("restart_pc", 32'(bus.instr_pc), 32'd0);

    // Redirect while the word for address 1 is returning
    reset_dut();
    pulse_start();
    wait_valid(n);
    tick();
    tick();
    bus.redirect = 1'b1;
    bus.redirect_addr = 3'd5;
    tick();
    bus.redirect = 1'b0;
    chk("rdw_valid", 32'(bus.instr_valid), 32'd0);
    chk("rdw_read", 32'(bus.rom_read), 32'd1);
    chk("rdw_addr", 32'(bus.rom_addr), 32'd5);
    wait_valid(n);
    chk("rdw_latency", 32'(n), 32'd3);
    chk("rdw_instr", 32'(bus.instr), 32'hC3CA);
    chk("rdw_pc", 32'(bus.instr_pc), 32'd5);
    chk("rdw_halted", 32'(bus.halted), 32'd0);

    // Redirect coinciding with a handshake
    reset_dut();
    base = hs_cnt;
    pulse_start();
    wait_valid(n);
    tick();
    wait_valid(n);
    tick();
    wait_valid(n);
    chk("rdh_pc_before", 32'(bus.instr_pc), 32'd2);
    bus.redirect = 1'b1;
    bus.redirect_addr = 3'd6;
    tick();
    bus.redirect = 1'b0;
    chk("rdh_consumed", 32'(hs_cnt - base), 32'd3);
    chk("rdh_addr", 32'(bus.rom_addr), 32'd6);
    wait_valid(n);
    chk("rdh_latency", 32'(n), 32'd3);
    chk("rdh_instr", 32'(bus.instr), 32'hD3C1);
    chk("rdh_pc", 32'(bus.instr_pc), 32'd6);

    // Asynchronous reset in the middle of an ISSUE cycle
    reset_dut();
    pulse_start();
    wait_valid(n);
    tick();
    wait_valid(n);
    bus.instr_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_read", 32'(bus.rom_read), 32'd0);
    chk("arst_halted", 32'(bus.halted), 32'd0);
    chk("arst_pc", 32'(bus.rom_addr), 32'd0);
    chk("arst_instr", 32'(bus.instr), 32'd0);
    tick();
    chk("arst_idle_valid", 32'(bus.instr_valid), 32'd0);
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    tick();
    chk("arst_idle_read", 32'(bus.rom_read), 32'd0);
    pulse_start();
    wait_valid(n);
    chk("arst_restart_latency", 32'(n), 32'd3);
    chk("arst_restart_pc", 32'(bus.instr_pc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch/decode controller that drives the program ROM, which has a 1-cycle registered read (clk, read, addr, data_out).
- Holds the program counter and issues ROM reads.
- Latches each returned word into an instruction register, decodes it and hands it to the execute stage over a valid/ready handshake.
- Supports start, an external PC redirect, halt on an all-zero word, and an illegal-opcode trap.

Parameters:
ADDR_W, 3, ROM address / PC width
START_ADDR, 0, PC value loaded on start

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin execution from START_ADDR; honoured only in IDLE or HALT
rom_read  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM address (= pc)
rom_data  in  16  ROM data_out; valid the cycle after rom_read
instr_valid  out  1  decoded instruction available to execute stage
instr_ready  in  1  execute stage accepts instruction
instr  out  16  raw instruction register
op_sel  out  3  decoded op: 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 MVI, 7 LDA
dst  out  6  instr[11:6]
src  out  6  instr[5:0] (immediate/address for MVI/LDA)
instr_pc  out  ADDR_W  address the current instruction was fetched from
redirect  in  1  load new PC, flushing in-flight work
redirect_addr  in  ADDR_W  redirect target
halted  out  1  sticky; set on HALT word or illegal opcode
illegal  out  1  sticky; set on illegal opcode

Behaviour:
- Instruction format: [15:12] opcode, [11:6] dst, [5:0] src.
  - Opcodes: 0x1 MOV, 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0xC MVI, 0xD LDA.
  - Word 0x0000 = HALT.
  - Any other opcode, or opcode 0x0 with nonzero operands, is illegal.
- Reset (async): state IDLE, pc=START_ADDR, instr=0, op_sel=0, instr_pc=0, halted=0, illegal=0, rom_read=0, instr_valid=0.
- States: IDLE, FETCH, WAIT, ISSUE, HALT.
  - IDLE: start -> pc<=START_ADDR, clear halted/illegal, go FETCH.
  - FETCH: rom_read=1, rom_addr=pc (combinational from state/pc); next WAIT.
  - WAIT: rom_data valid this cycle. At the edge:
    - Valid opcode: latch instr/op_sel/dst/src, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W), go ISSUE.
    - HALT word: halted<=1, go HALT; pc stays at the HALT address.
    - Illegal opcode: halted<=1, illegal<=1, instr<=word, instr_pc<=pc, go HALT.
  - ISSUE: instr_valid=1. Outputs stay stable until instr_valid&&instr_ready; on handshake go FETCH.
  - HALT: rom_read=0, instr_valid=0; start behaves as in IDLE (restart).
- Throughput: 3 cycles per instruction with instr_ready held high. First instr_valid appears in the 3rd cycle after the start edge.
- rom_read is asserted only in FETCH. The ROM address never changes while a read is outstanding.
- redirect, sampled in FETCH/WAIT/ISSUE:
  - pc<=redirect_addr, go FETCH.
  - Any in-flight ROM word is discarded; instr_valid drops the next cycle.
  - Redirect in the same cycle as an ISSUE handshake: the handshake completes (instruction consumed) and redirect sets the next PC.
  - Redirect in WAIT: the returned word is ignored and no halt/illegal update occurs.
  - Ignored in IDLE/HALT.
- start outside IDLE/HALT is ignored. start together with redirect in IDLE/HALT: start wins.
- pc wraps from 2^ADDR_W-1 to 0 with no flag.
- Reset asserted mid-operation returns immediately to the reset state; a ROM read in progress is abandoned.

Test Plan:
- Bench ROM (1-cycle registered) = [0x1042, 0x2043, 0x3044, 0x4045, 0x5046, 0xC3CA, 0xD3C1, 0x0000]; ready=1; pulse start -> seven issues, first (0x1042, op_sel=1, dst=1, src=2, instr_pc=0) in the 3rd cycle after start, one every 3 cycles; then halted=1, illegal=0, no further rom_read.
- Same ROM, instr_ready low for 5 cycles on the 0x2043 issue -> instr_valid held 6 cycles with instr/op_sel/instr_pc stable, no rom_read during the stall, next fetch at address 2.
- ROM[2]=0x7001 -> after instr_pc=1 issues, halted=1, illegal=1, instr=0x7001, instr_pc=2; start then restarts from 0 with both flags cleared.
- redirect=1, redirect_addr=5 asserted during WAIT for address 1 -> word 0x2043 never issued, next issue is 0xC3CA with instr_pc=5.
- Redirect to 6 coinciding with the handshake of instr_pc=2 -> 0x3044 counted as consumed, next issue instr_pc=6 (0xD3C1).
- Async rst pulse mid-ISSUE (between edges) -> instr_valid, rom_read, halted immediately 0; state IDLE; pc=0.
